serial_bit_feeder: RTL and testbench

//   Upstream stage for the serial sequence detectors (e.g. the 100110 Moore

---
 rtl/serial_bit_feeder.sv | 153 +++++++++++++++
 tb/tb_serial_bit_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - word FIFO feeding a gap-free 1-bit serial stream
//
// Purpose:
//   Buffers parallel words pushed through a valid/ready handshake and
//   serializes them onto D, one bit per clock. Buffered words follow each
//   other back-to-back. IDLE_BIT is driven on D while nothing is being sent.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst_       asynchronous active-low reset
//   in_data    word to enqueue
//   in_valid   in_data valid this cycle
//   in_ready   FIFO has room (count < DEPTH), from registered count only
//   D          serial bit stream (registered)
//   bit_valid  D carries a data bit this cycle (registered)
//   busy       word in flight or FIFO not empty
//   count      words held in the FIFO, excluding the in-flight word
module serial_bit_feeder #(
   parameter int   WIDTH     = 8,
   parameter int   DEPTH     = 4,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   D,
   output logic                   bit_valid,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(WIDTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] head_ord;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    idx_nxt;
   logic             d_nxt;
   logic             bv_nxt;
   logic             push;
   logic             pop;
   logic             last_bit;

   assign in_ready = (count < FULL_CNT);
   assign push     = in_valid && in_ready;
   assign last_bit = (state == ST_SHIFT) && (idx == LAST_IDX);
   // A word is taken when idle, or while its predecessor's last bit is on D.
   assign pop      = (count != '0) && ((state == ST_IDLE) || last_bit);
   assign busy     = (state == ST_SHIFT) || (count != '0);

   // Reorder the head word so the next bit to send is always at bit 0.
   assign head     = mem[rd_ptr];
   assign head_ord = (MSB_FIRST != 0) ? {<<{head}} : head;

   // FIFO storage carries no reset; count and pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (pop) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit && !pop) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered serial outputs
   always_comb begin
      d_nxt     = IDLE_BIT;
      bv_nxt    = 1'b0;
      idx_nxt   = '0;
      shreg_nxt = shreg;
      if (pop) begin
         d_nxt     = head_ord[0];
         bv_nxt    = 1'b1;
         shreg_nxt = head_ord >> 1;
      end else if ((state == ST_SHIFT) && !last_bit) begin
         d_nxt     = shreg[0];
         bv_nxt    = 1'b1;
         idx_nxt   = idx + IW'(1);
         shreg_nxt = shreg >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         D         <= IDLE_BIT;
         bit_valid <= 1'b0;
         idx       <= '0;
         shreg     <= '0;
      end else begin
         D         <= d_nxt;
         bit_valid <= bv_nxt;
         idx       <= idx_nxt;
         shreg     <= shreg_nxt;
      end
   end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - randomized and directed bench for serial_bit_feeder
module tb_serial_bit_feeder;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_ = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;

   logic             in_ready_m, d_m, bv_m, busy_m;
   logic [CW-1:0]    count_m;
   logic             in_ready_l, d_l, bv_l, busy_l;
   logic [CW-1:0]    count_l;

   always #5 clk = ~clk;

   serial_bit_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_msb (
      .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_m), .D(d_m), .bit_valid(bv_m), .busy(busy_m), .count(count_m)
   );

   serial_bit_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_l), .D(d_l), .bit_valid(bv_l), .busy(busy_l), .count(count_l)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of buffered words plus the queue of bits still
   // to appear on D (head = bit currently shown). Both instances share the
   // word queue; only the bit order of the flight queue differs.
   logic [WIDTH-1:0] mq[$];
   bit               fl_m[$];
   bit               fl_l[$];

   task automatic model_clear();
      mq.delete();
      fl_m.delete();
      fl_l.delete();
   endtask

   always @(negedge rst_) model_clear();

   always @(posedge clk) begin
      bit               do_push;
      bit               do_pop;
      logic [WIDTH-1:0] w;
      if (!rst_) begin
         model_clear();
      end else begin
         do_push = in_valid && (mq.size() < DEPTH);
         do_pop  = (mq.size() != 0) && (fl_m.size() <= 1);
         if (fl_m.size() != 0) begin
            void'(fl_m.pop_front());
            void'(fl_l.pop_front());
         end
         if (do_pop) begin
            w = mq.pop_front();
            for (int i = 0; i < WIDTH; i++) begin
               fl_m.push_back(w[WIDTH-1-i]);
               fl_l.push_back(w[i]);
            end
         end
         if (do_push) mq.push_back(in_data);
      end
   end

   // Per-cycle comparison against the model
   int max_cnt  = 0;
   bit saw_full = 1'b0;

   always @(negedge clk) begin
      bit e_bv;
      e_bv = (fl_m.size() != 0);
      check("msb_bit_valid", bv_m, e_bv);
      check("lsb_bit_valid", bv_l, e_bv);
      check("msb_d", d_m, e_bv ? fl_m[0] : 1'b0);
      check("lsb_d", d_l, e_bv ? fl_l[0] : 1'b0);
      check("msb_count", count_m, mq.size());
      check("lsb_count", count_l, mq.size());
      check("msb_busy", busy_m, e_bv || (mq.size() != 0));
      check("lsb_busy", busy_l, e_bv || (mq.size() != 0));
      check("msb_in_ready", in_ready_m, mq.size() < DEPTH);
      check("lsb_in_ready", in_ready_l, mq.size() < DEPTH);
      if (int'(count_m) > max_cnt) max_cnt = int'(count_m);
      if (!in_ready_m) saw_full = 1'b1;
   end

   logic [WIDTH-1:0] words[8];

   task automatic send_words(input int n);
      int i;
      int guard;
      bit acc;
      i = 0;
      guard = 0;
      while (i < n && guard < 200) begin
         in_data  = words[i];
         in_valid = 1'b1;
         acc      = in_ready_m;
         @(negedge clk);
         if (acc) i++;
         guard++;
      end
      in_valid = 1'b0;
      check("send_words_done", i, n);
   endtask

   task automatic capture(input int n, output logic [63:0] sm, output logic [63:0] sl,
                          output int wait_cyc, output int gaps);
      sm = '0;
      sl = '0;
      wait_cyc = 0;
      gaps = 0;
      while (!bv_m && wait_cyc < 50) begin
         @(negedge clk);
         wait_cyc++;
      end
      for (int i = 0; i < n; i++) begin
         if (!bv_m) gaps++;
         sm = {sm[62:0], d_m};
         sl = {sl[62:0], d_l};
         @(negedge clk);
      end
   endtask

   initial begin
      logic [63:0] sm, sl;
      int wc, gp, hits, vb;

      // Reset values while rst_ is held low
      repeat (3) @(negedge clk);
      check("rst_d", d_m, 1'b0);
      check("rst_bit_valid", bv_m, 1'b0);
      check("rst_count", count_m, 0);
      check("rst_busy", busy_m, 1'b0);
      check("rst_in_ready", in_ready_m, 1'b1);
      rst_ = 1'b1;
      @(negedge clk);

      // Single word 8'b1001_1000: one-cycle push latency, then 8 bits
      in_data = 8'h98;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("lat_count_after_push", count_m, 1);
      check("lat_no_bit_yet", bv_m, 1'b0);
      capture(8, sm, sl, wc, gp);
      check("lat_first_bit_cycle", wc, 1);
      check("w98_gaps", gp, 0);
      check("w98_msb_stream", sm[7:0], 8'h98);
      check("w98_lsb_stream", sl[7:0], 8'h19);
      check("w98_idle_bv", bv_m, 1'b0);
      check("w98_idle_d", d_m, 1'b0);
      hits = 0;
      for (int i = 0; i < 3; i++) begin
         if (sm[7-i -: 6] == 6'b100110) hits++;
      end
      check("w98_detect_hits", hits, 1);
      repeat (2) @(negedge clk);

      // LSB-first instance with 8'h19 gives the same 1,0,0,1,1,0,0,0 stream
      in_data = 8'h19;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      capture(8, sm, sl, wc, gp);
      check("w19_lsb_stream", sl[7:0], 8'h98);
      check("w19_msb_stream", sm[7:0], 8'h19);
      repeat (2) @(negedge clk);

      // Two words on consecutive cycles -> 16 contiguous bits
      in_data = 8'hA5;
      in_valid = 1'b1;
      @(negedge clk);
      in_data = 8'h3C;
      @(negedge clk);
      in_valid = 1'b0;
      capture(16, sm, sl, wc, gp);
      check("pair_gaps", gp, 0);
      check("pair_msb_stream", sm[15:0], 16'hA53C);
      check("pair_lsb_stream", sl[15:0], 16'hA53C);
      check("pair_idle_after", bv_m, 1'b0);
      repeat (2) @(negedge clk);

      // Six words with in_valid held high: backpressure at count = DEPTH
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
      max_cnt = 0;
      saw_full = 1'b0;
      fork
         send_words(6);
         capture(48, sm, sl, wc, gp);
      join
      check("six_gaps", gp, 0);
      check("six_msb_stream", sm[47:0], 48'h112233445566);
      check("six_max_count", max_cnt, DEPTH);
      check("six_saw_full", saw_full, 1'b1);
      check("six_idle_after", bv_m, 1'b0);
      repeat (2) @(negedge clk);

      // Mid-word async reset with two words queued
      in_valid = 1'b1;
      in_data = 8'hAA;
      @(negedge clk);
      in_data = 8'hBB;
      @(negedge clk);
      in_data = 8'hCC;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_third_bit_valid", bv_m, 1'b1);
      check("mid_third_bit_d", d_m, 1'b1);
      check("mid_queued", count_m, 2);
      #2 rst_ = 1'b0;
      #1;
      check("async_d", d_m, 1'b0);
      check("async_bit_valid", bv_m, 1'b0);
      check("async_count", count_m, 0);
      check("async_busy", busy_m, 1'b0);
      check("async_in_ready", in_ready_m, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_ = 1'b1;
      vb = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bv_m || bv_l) vb++;
      end
      check("post_reset_no_bits", vb, 0);

      // Randomized traffic at three load levels, with one mid-cycle reset
      for (int seg = 0; seg < 3; seg++) begin
         int p;
         p = (seg == 0) ? 15 : (seg == 1) ? 40 : 90;
         for (int c = 0; c < 200; c++) begin
            if (seg == 2 && c == 100) begin
               #2 rst_ = 1'b0;
               @(negedge clk);
               rst_ = 1'b1;
            end
            in_valid = ($urandom_range(0, 99) < p);
            in_data  = WIDTH'($urandom);
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      repeat (60) @(negedge clk);
      check("drain_busy", busy_m, 1'b0);
      check("drain_count", count_m, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
